// File: rtl/store_buffer_unit.sv
// Store path with a DEPTH-entry write buffer: computes the effective address, lane-aligns
// data and byte enables, queues stores and drains them to data memory over req/ack.
module store_buffer_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [XLEN-1:0]          rs1_val,
    input  logic [XLEN-1:0]          rs2_val,
    input  logic [XLEN-1:0]          imm,
    input  logic [2:0]               store_control,
    input  logic                     i_fence,
    input  logic                     ld_chk_valid,
    input  logic [XLEN-1:0]          ld_chk_addr,
    input  logic                     mem_ack,
    output logic                     stall_pc,
    output logic                     misaligned_exc,
    output logic                     ld_hazard,
    output logic                     mem_req,
    output logic                     mem_rw_mode,
    output logic [XLEN-1:0]          mem_addr,
    output logic [XLEN-1:0]          mem_write_data,
    output logic [XLEN/8-1:0]        mem_byte_en,
    output logic                     buf_empty,
    output logic [$clog2(DEPTH):0]   buf_count
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    localparam logic [2:0] STR_NOP = 3'd0;
    localparam logic [2:0] STR_SB  = 3'd1;
    localparam logic [2:0] STR_SH  = 3'd2;
    localparam logic [2:0] STR_SW  = 3'd3;
    localparam logic [2:0] STR_SD  = 3'd4;

    logic [XLEN-1:0] ea;
    logic [OFFW-1:0] off;
    logic [XLEN-1:0] st_data;
    logic [NB-1:0]   st_be;
    logic            st_valid;
    logic            misaligned;
    logic            push;
    logic            pop;
    logic            full;

    logic [XLEN-1:0] addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [NB-1:0]   be_q   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic unused_ld_off;

    assign ea  = rs1_val + imm;
    assign off = ea[OFFW-1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        st_valid   = 1'b0;
        misaligned = 1'b0;
        st_be      = '0;
        st_data    = '0;
        case (store_control)
            STR_SB: begin
                st_valid = 1'b1;
                st_be    = NB'(1) << off;
                st_data  = XLEN'(rs2_val[7:0]) << {off, 3'b000};
            end
            STR_SH: begin
                st_valid   = 1'b1;
                misaligned = ea[0];
                st_be      = NB'(2'b11) << off;
                st_data    = XLEN'(rs2_val[15:0]) << {off, 3'b000};
            end
            STR_SW: begin
                st_valid   = 1'b1;
                misaligned = (ea[1:0] != 2'b00);
                st_be      = NB'(4'hF) << off;
                st_data    = XLEN'(rs2_val[31:0]) << {off, 3'b000};
            end
            STR_SD: begin
                // A doubleword store only exists on a 64-bit datapath; otherwise it is a no-op.
                if (XLEN == 64) begin
                    st_valid   = 1'b1;
                    misaligned = (ea[2:0] != 3'b000);
                    st_be      = '1;
                    st_data    = rs2_val;
                end
            end
            default: ;
        endcase
    end

    assign full           = (count == CW'(DEPTH));
    assign push           = st_valid && !misaligned && !full;
    assign pop            = mem_req && mem_ack;
    assign misaligned_exc = st_valid && misaligned;
    assign stall_pc       = (st_valid && !misaligned && full) || (i_fence && (count != '0));

    // NOTE: the entry arrays carry no reset; valid_q and count gate every read of them.
    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_q[tail] <= ea;
            data_q[tail] <= st_data;
            be_q[tail]   <= st_be;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                tail          <= tail + 1'b1;
                valid_q[tail] <= 1'b1;
            end
            if (pop) begin
                head          <= head + 1'b1;
                valid_q[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign buf_empty      = (count == '0);
    assign buf_count      = count;
    assign mem_req        = !buf_empty;
    assign mem_rw_mode    = !mem_req;
    assign mem_addr       = mem_req ? addr_q[head] : '0;
    assign mem_write_data = mem_req ? data_q[head] : '0;
    assign mem_byte_en    = mem_req ? be_q[head]   : '0;

    // Word-granular overlap check against every buffered store, head included.
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ld_chk_valid && valid_q[i] &&
                (addr_q[i][XLEN-1:OFFW] == ld_chk_addr[XLEN-1:OFFW]))
                ld_hazard = 1'b1;
        end
    end

    assign unused_ld_off = ^ld_chk_addr[OFFW-1:0];
endmodule

// File: doc/store_buffer_unit.md
Name: store_buffer_unit

Overview:
Parametrised successor of the single-cycle store path. It computes the effective address, lane-aligns the data and generates byte enables, then queues each store in a DEPTH-entry FIFO. It drains the FIFO to data memory through a req/ack handshake, so the core stalls only when the buffer is full, on a fence, or never for misaligned stores (those raise an exception instead). It sits between the execute stage and the data-memory port and also provides a store-to-load address hazard check.

Parameters:
XLEN, 32, datapath/address width; legal values 32 or 64.
DEPTH, 4, store buffer entries; power of two, at least 2.

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, asynchronous, active-high
rs1_val  input  XLEN  base address operand
rs2_val  input  XLEN  store data operand
imm  input  XLEN  sign-extended offset
store_control  input  3  SB/SH/SW/SD/STR_NOP codes from processor_defines; SD is legal only when XLEN=64, otherwise treated as STR_NOP
i_fence  input  1  drain request; asserted only alongside STR_NOP
ld_chk_valid  input  1  a load in execute needs a hazard check
ld_chk_addr  input  XLEN  that load's effective address
mem_ack  input  1  memory accepted the presented write
stall_pc  output  1  hold PC and the current instruction
misaligned_exc  output  1  current store is misaligned and is dropped
ld_hazard  output  1  load overlaps a buffered store
mem_req  output  1  write presented on the memory port
mem_rw_mode  output  1  0 = write, 1 = read/idle
mem_addr  output  XLEN  head-entry address
mem_write_data  output  XLEN  head-entry lane-aligned data
mem_byte_en  output  XLEN/8  head-entry byte enables
buf_empty  output  1  no valid entries
buf_count  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (async assert, synchronous release): head, tail and count go to 0. mem_req=0, mem_rw_mode=1, mem_addr, mem_write_data and mem_byte_en all 0, buf_empty=1. Asserting reset mid-transaction discards every entry and drops mem_req immediately.
- Effective address: ea = rs1_val + imm, modulo 2^XLEN; the carry is discarded.
- Lane index: off = ea[log2(XLEN/8)-1:0].
- Data: rs2_val is shifted left by 8*off bits. Unused lanes are 0.
- Byte enables: SB gives 1<<off, SH gives 2'b11<<off, SW gives 4'hF<<off, SD gives 8'hFF.
- Misalignment (combinational): SH with ea[0]!=0, SW with ea[1:0]!=0, SD with ea[2:0]!=0. The result is misaligned_exc=1 for that cycle, no push, stall_pc=0.
- Push: a valid, aligned store with count<DEPTH is written at tail on the rising edge, and tail increments with wrap at DEPTH. There is no stall.
- Full: a valid store with count==DEPTH gives stall_pc=1 and no push. The full decision uses the registered count, with no same-cycle bypass from a concurrent pop. The store is pushed in the cycle after a slot frees.
- Drain: mem_req = !buf_empty. mem_addr, mem_write_data and mem_byte_en show the head entry and must stay stable while mem_req=1 and mem_ack=0. A pop happens on an edge where mem_req&&mem_ack; head then increments with wrap. mem_ack while mem_req=0 is ignored. mem_rw_mode = !mem_req. When the buffer is idle, the data, address and byte-enable outputs are 0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Fence: i_fence=1 with count>0 gives stall_pc=1, held until the cycle count reads 0. With count==0, a fence causes no stall.
- Hazard: ld_hazard=1 when ld_chk_valid is set and any valid entry has an equal word address (addr>>log2(XLEN/8)). The check is combinational over all entries, including the head while it is being acked. The core stalls the load on ld_hazard; this block does not forward data.
- STR_NOP and undefined codes: no push, no exception, stall_pc = the fence condition only.

Test Plan:
1. XLEN=32, DEPTH=4. SB with rs1=0x1000, imm=3, rs2=0xAB, mem_ack=1 -> pushed, no stall. Next cycle mem_req=1, mem_addr=0x1003, data=0xAB000000, be=4'b1000, mem_rw_mode=0. Popped, then buf_empty=1.
2. Hold mem_ack=0 and issue 5 SW to 0x2000, 0x2004, 0x2008, 0x200C, 0x2010 -> count reaches 4. The 5th sees stall_pc=1 and no push, with the head (0x2000) stable throughout. Pulse mem_ack -> the 5th is pushed one cycle after count drops to 3.
3. SH to 0x3001 -> misaligned_exc=1, stall_pc=0, count unchanged. SW to 0x3002 -> exception. SH to 0x3002 -> data=rs2[15:0]<<16, be=4'b1100.
4. Buffer holds SW 0x4008. Load check at 0x400A -> ld_hazard=1. Check at 0x400C -> 0. Once the entry is acked -> 0x400A reads 0.
5. Three entries queued, ack withheld, then i_fence=1 -> stall_pc=1 until 3 acks. stall_pc=0 in the cycle count reads 0.
6. Two entries queued, mem_req=1, assert i_rst mid-cycle -> mem_req=0 and buf_empty=1 immediately, all outputs 0. After release, a subsequent SW drains normally. XLEN=64: SD to 0x8 gives be=8'hFF.
